// File: rtl/skin_bbox_tracker.sv
// rtl/skin_bbox_tracker.sv - run-length filtered skin bounding box and pixel count per frame
module skin_bbox_tracker #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int MIN_RUN    = 8,
    parameter int MIN_PIXELS = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixel_valid,
    input  logic        skin_in,
    input  logic        frame_start,
    output logic [9:0]  x_min,
    output logic [9:0]  x_max,
    output logic [9:0]  y_min,
    output logic [9:0]  y_max,
    output logic [18:0] skin_count,
    output logic        face_found,
    output logic        bbox_valid,
    output logic        busy
);

    localparam logic [9:0]  LAST_COL  = 10'(IMG_WIDTH - 1);
    localparam logic [9:0]  LAST_ROW  = 10'(IMG_HEIGHT - 1);
    localparam logic [5:0]  RUN_SAT   = 6'(MIN_RUN);
    localparam logic [5:0]  RUN_PRE   = 6'(MIN_RUN - 1);
    localparam logic [9:0]  RUN_BACK  = 10'(MIN_RUN - 1);
    localparam logic [19:0] RUN_ADD   = 20'(MIN_RUN);
    localparam logic [18:0] FACE_THR  = 19'(MIN_PIXELS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic [5:0]  run_q, run_d;
    logic        has_skin_q, has_skin_d;
    logic [9:0]  wx_min_q, wx_min_d;
    logic [9:0]  wx_max_q, wx_max_d;
    logic [9:0]  wy_min_q, wy_min_d;
    logic [9:0]  wy_max_q, wy_max_d;
    logic [18:0] wcount_q, wcount_d;

    logic [9:0]  x_min_q, x_min_d;
    logic [9:0]  x_max_q, x_max_d;
    logic [9:0]  y_min_q, y_min_d;
    logic [9:0]  y_max_q, y_max_d;
    logic [18:0] skin_count_q, skin_count_d;
    logic        face_found_q, face_found_d;
    logic        bbox_valid_q, bbox_valid_d;

    // Per-pixel working values: "base" is the state the pixel builds on (cleared on a
    // frame start), "p_" is the result after folding this pixel in.
    logic        accept, restart, line_end, frame_end;
    logic        confirm_first, confirm_more;
    logic [9:0]  b_col, b_row, b_xmin, b_xmax, b_ymin, b_ymax;
    logic [5:0]  b_run;
    logic        b_has;
    logic [18:0] b_cnt;
    logic [9:0]  cand_xmin;
    logic [9:0]  p_xmin, p_xmax, p_ymin, p_ymax;
    logic        p_has;
    logic [19:0] cnt_sum;
    logic [18:0] p_cnt;

    // Next-state, run-length filter, box accumulation and report latching.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        run_d        = run_q;
        has_skin_d   = has_skin_q;
        wx_min_d     = wx_min_q;
        wx_max_d     = wx_max_q;
        wy_min_d     = wy_min_q;
        wy_max_d     = wy_max_q;
        wcount_d     = wcount_q;
        x_min_d      = x_min_q;
        x_max_d      = x_max_q;
        y_min_d      = y_min_q;
        y_max_d      = y_max_q;
        skin_count_d = skin_count_q;
        face_found_d = face_found_q;
        bbox_valid_d = 1'b0;
        accept       = 1'b0;
        restart      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pixel_valid && frame_start) begin
                    accept  = 1'b1;
                    restart = 1'b1;
                end
            end
            ACCUM: begin
                if (pixel_valid) begin
                    accept  = 1'b1;
                    restart = frame_start;
                end
            end
            REPORT: begin
                // frame_start arriving here is deliberately ignored.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        b_col  = restart ? 10'd0 : col_q;
        b_row  = restart ? 10'd0 : row_q;
        b_run  = restart ? 6'd0  : run_q;
        b_has  = restart ? 1'b0  : has_skin_q;
        b_xmin = restart ? 10'd0 : wx_min_q;
        b_xmax = restart ? 10'd0 : wx_max_q;
        b_ymin = restart ? 10'd0 : wy_min_q;
        b_ymax = restart ? 10'd0 : wy_max_q;
        b_cnt  = restart ? 19'd0 : wcount_q;

        line_end  = (b_col == LAST_COL);
        frame_end = line_end && (b_row == LAST_ROW);

        // The pixel that brings the run to MIN_RUN confirms the whole run; later
        // pixels of the same run extend it one at a time.
        confirm_first = skin_in && (b_run == RUN_PRE);
        confirm_more  = skin_in && (b_run == RUN_SAT);
        cand_xmin     = confirm_first ? (b_col - RUN_BACK) : b_col;

        p_xmin = b_xmin;
        p_xmax = b_xmax;
        p_ymin = b_ymin;
        p_ymax = b_ymax;
        p_has  = b_has;
        if (confirm_first || confirm_more) begin
            p_has = 1'b1;
            if (!b_has) begin
                p_xmin = cand_xmin;
                p_xmax = b_col;
                p_ymin = b_row;
                p_ymax = b_row;
            end else begin
                p_xmin = (cand_xmin < b_xmin) ? cand_xmin : b_xmin;
                p_xmax = (b_col > b_xmax)     ? b_col     : b_xmax;
                p_ymin = (b_row < b_ymin)     ? b_row     : b_ymin;
                p_ymax = (b_row > b_ymax)     ? b_row     : b_ymax;
            end
        end

        cnt_sum = {1'b0, b_cnt} + (confirm_first ? RUN_ADD : 20'd1);
        if (!(confirm_first || confirm_more)) begin
            p_cnt = b_cnt;
        end else if (cnt_sum[19]) begin
            p_cnt = '1;
        end else begin
            p_cnt = cnt_sum[18:0];
        end

        if (accept) begin
            has_skin_d = p_has;
            wx_min_d   = p_xmin;
            wx_max_d   = p_xmax;
            wy_min_d   = p_ymin;
            wy_max_d   = p_ymax;
            wcount_d   = p_cnt;

            // Runs never carry across a line boundary.
            if (line_end || !skin_in) begin
                run_d = 6'd0;
            end else if (b_run == RUN_SAT) begin
                run_d = RUN_SAT;
            end else begin
                run_d = b_run + 6'd1;
            end

            if (line_end) begin
                col_d = 10'd0;
                row_d = frame_end ? 10'd0 : b_row + 10'd1;
            end else begin
                col_d = b_col + 10'd1;
                row_d = b_row;
            end

            if (frame_end) begin
                // Outputs move on the last pixel's edge so they are already stable
                // during the REPORT cycle when bbox_valid is high.
                state_d      = REPORT;
                bbox_valid_d = 1'b1;
                x_min_d      = p_has ? p_xmin : 10'd0;
                x_max_d      = p_has ? p_xmax : 10'd0;
                y_min_d      = p_has ? p_ymin : 10'd0;
                y_max_d      = p_has ? p_ymax : 10'd0;
                skin_count_d = p_has ? p_cnt  : 19'd0;
                face_found_d = p_has && (p_cnt >= FACE_THR);
            end else begin
                state_d = ACCUM;
            end
        end
    end

    // State, working and output registers; a reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            run_q        <= '0;
            has_skin_q   <= 1'b0;
            wx_min_q     <= '0;
            wx_max_q     <= '0;
            wy_min_q     <= '0;
            wy_max_q     <= '0;
            wcount_q     <= '0;
            x_min_q      <= '0;
            x_max_q      <= '0;
            y_min_q      <= '0;
            y_max_q      <= '0;
            skin_count_q <= '0;
            face_found_q <= 1'b0;
            bbox_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            run_q        <= run_d;
            has_skin_q   <= has_skin_d;
            wx_min_q     <= wx_min_d;
            wx_max_q     <= wx_max_d;
            wy_min_q     <= wy_min_d;
            wy_max_q     <= wy_max_d;
            wcount_q     <= wcount_d;
            x_min_q      <= x_min_d;
            x_max_q      <= x_max_d;
            y_min_q      <= y_min_d;
            y_max_q      <= y_max_d;
            skin_count_q <= skin_count_d;
            face_found_q <= face_found_d;
            bbox_valid_q <= bbox_valid_d;
        end
    end

    assign x_min      = x_min_q;
    assign x_max      = x_max_q;
    assign y_min      = y_min_q;
    assign y_max      = y_max_q;
    assign skin_count = skin_count_q;
    assign face_found = face_found_q;
    assign bbox_valid = bbox_valid_q;
    assign busy       = (state_q == ACCUM);

endmodule

// File: tb/tb_skin_bbox_tracker.sv
// tb/tb_skin_bbox_tracker.sv - scoreboard bench for skin_bbox_tracker on a 16x8 frame
module tb_skin_bbox_tracker;

    logic        clk;
    logic        rst_n;
    logic        pixel_valid;
    logic        skin_in;
    logic        frame_start;
    logic [9:0]  x_min, x_max, y_min, y_max;
    logic [18:0] skin_count;
    logic        face_found;
    logic        bbox_valid;
    logic        busy;

    skin_bbox_tracker #(
        .IMG_WIDTH (16),
        .IMG_HEIGHT(8),
        .MIN_RUN   (4),
        .MIN_PIXELS(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_valid(pixel_valid),
        .skin_in    (skin_in),
        .frame_start(frame_start),
        .x_min      (x_min),
        .x_max      (x_max),
        .y_min      (y_min),
        .y_max      (y_max),
        .skin_count (skin_count),
        .face_found (face_found),
        .bbox_valid (bbox_valid),
        .busy       (busy)
    );

    typedef struct {
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int cnt;
        int face;
        int acc_edge;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [15:0] img [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    // Monitor: every bbox_valid pulse must match the oldest expected report.
    always @(negedge clk) begin
        if (rst_n && bbox_valid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_bbox_valid: got pulse at cycle %0d, expected none", cyc);
            end else begin
                automatic exp_t e = sb_q.pop_front();
                chk("latency_edge", cyc, e.acc_edge);
                chk("x_min", {22'd0, x_min}, e.xmin);
                chk("x_max", {22'd0, x_max}, e.xmax);
                chk("y_min", {22'd0, y_min}, e.ymin);
                chk("y_max", {22'd0, y_max}, e.ymax);
                chk("skin_count", {13'd0, skin_count}, e.cnt);
                chk("face_found", {31'd0, face_found}, e.face);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            pixel_valid = 1'b0;
            skin_in     = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    task automatic drive_pix(input logic sk, input logic fs, input bit gaps, output int acc_e);
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
                pixel_valid = 1'b0;
                skin_in     = 1'($urandom_range(0, 1));
                frame_start = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk);
        #1;
        pixel_valid = 1'b1;
        skin_in     = sk;
        frame_start = fs;
        acc_e       = cyc + 1;
    endtask

    task automatic send_rows(input int nrows, input bit gaps, output int last_e);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < 16; c++) begin
                drive_pix(img[r][c], (r == 0 && c == 0), gaps, last_e);
            end
        end
    endtask

    task automatic clr_img();
        for (int r = 0; r < 8; r++) img[r] = 16'h0000;
    endtask

    task automatic push_exp(input int xa, input int xb, input int ya, input int yb,
                            input int cn, input int fc, input int ae);
        exp_t e;
        e.xmin = xa; e.xmax = xb; e.ymin = ya; e.ymax = yb;
        e.cnt = cn; e.face = fc; e.acc_edge = ae;
        sb_q.push_back(e);
    endtask

    task automatic load_box_img();
        clr_img();
        for (int r = 2; r <= 5; r++) img[r] = 16'h1FE0;
    endtask

    initial begin
        int last_e;
        int wait_n;
        rst_n       = 1'b0;
        pixel_valid = 1'b0;
        skin_in     = 1'b0;
        frame_start = 1'b0;
        #1;
        chk("reset_x_min", {22'd0, x_min}, 0);
        chk("reset_y_max", {22'd0, y_max}, 0);
        chk("reset_count", {13'd0, skin_count}, 0);
        chk("reset_face", {31'd0, face_found}, 0);
        chk("reset_bbox_valid", {31'd0, bbox_valid}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Solid block rows 2..5, cols 5..12: 32 pixels, meets threshold of 32.
        load_box_img();
        send_rows(8, 1'b0, last_e);
        push_exp(5, 12, 2, 5, 32, 1, last_e);
        idle(3);

        // Runs of three everywhere: nothing confirmed, report still issued.
        clr_img();
        for (int r = 0; r < 8; r++) img[r] = 16'h7777;
        send_rows(8, 1'b0, last_e);
        push_exp(0, 0, 0, 0, 0, 0, last_e);
        idle(3);

        // Run at the end of row 1 confirmed; 3 pixels starting row 2 are not.
        clr_img();
        img[1] = 16'hF000;
        img[2] = 16'h0007;
        send_rows(8, 1'b0, last_e);
        push_exp(12, 15, 1, 1, 4, 0, last_e);
        idle(3);

        // Same block image with random valid gaps.
        load_box_img();
        send_rows(8, 1'b1, last_e);
        push_exp(5, 12, 2, 5, 32, 1, last_e);
        idle(3);

        // Frame aborted by frame_start at row 3, then a clean frame with skin rows 6..7.
        clr_img();
        for (int r = 0; r <= 2; r++) img[r] = 16'h03F0;
        send_rows(3, 1'b0, last_e);
        clr_img();
        img[6] = 16'hFF00;
        img[7] = 16'hFF00;
        send_rows(8, 1'b0, last_e);
        push_exp(8, 15, 6, 7, 16, 0, last_e);
        idle(3);

        // Reset in the middle of a frame.
        load_box_img();
        send_rows(4, 1'b0, last_e);
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        chk("busy_mid_frame", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #2;
        chk("midreset_x_max", {22'd0, x_max}, 0);
        chk("midreset_count", {13'd0, skin_count}, 0);
        chk("midreset_face", {31'd0, face_found}, 0);
        chk("midreset_busy", {31'd0, busy}, 0);
        chk("midreset_bbox_valid", {31'd0, bbox_valid}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_rows(8, 1'b0, last_e);
        push_exp(5, 12, 2, 5, 32, 1, last_e);
        idle(3);

        // One short of the threshold: 24 + 7 = 31 pixels.
        clr_img();
        for (int r = 2; r <= 4; r++) img[r] = 16'h1FE0;
        img[5] = 16'h0FE0;
        send_rows(8, 1'b0, last_e);
        push_exp(5, 12, 2, 5, 31, 0, last_e);
        idle(3);
        chk("outputs_hold_count", {13'd0, skin_count}, 31);

        wait_n = 0;
        while (sb_q.size() != 0 && wait_n < 20) begin
            @(posedge clk);
            wait_n++;
        end
        chk("scoreboard_drain", sb_q.size(), 0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/skin_bbox_tracker.md
Name: skin_bbox_tracker

Overview:
- Sits directly downstream of the per-pixel skin classifier. Consumes its per-pixel skin flag in raster order.
- Rejects isolated speckle with a horizontal run-length filter, then accumulates a per-frame bounding box and confirmed-skin pixel count.
- At end of frame, reports the box plus a face-present decision to the overlay/display stage.

Parameters:
- IMG_WIDTH, 640, active pixels per line.
- IMG_HEIGHT, 480, active lines per frame.
- MIN_RUN, 8, consecutive skin pixels in a line required before any of them count (range 1..63).
- MIN_PIXELS, 2000, confirmed-skin pixel count at or above which face_found is asserted.

Ports:
- clk  input  1  pixel clock.
- rst_n  input  1  asynchronous active-low reset.
- pixel_valid  input  1  qualifies skin_in and frame_start; pixels advance only when high.
- skin_in  input  1  per-pixel skin flag from the upstream classifier.
- frame_start  input  1  high with the first valid pixel (0,0) of a frame.
- x_min  output  10  leftmost confirmed-skin column.
- x_max  output  10  rightmost confirmed-skin column.
- y_min  output  10  topmost confirmed-skin row.
- y_max  output  10  bottom-most confirmed-skin row.
- skin_count  output  19  confirmed-skin pixels in the last frame.
- face_found  output  1  skin_count >= MIN_PIXELS.
- bbox_valid  output  1  one-cycle pulse when the outputs update.
- busy  output  1  high while in ACCUM.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal counters 0.
- Reset is asynchronous and may occur mid-frame. The partial frame is discarded; no bbox_valid is issued.

FSM states and transitions:
- IDLE → ACCUM on pixel_valid && frame_start. That pixel is processed as (col 0, row 0).
- ACCUM:
  - Each valid pixel advances col.
  - At col == IMG_WIDTH-1, col wraps to 0 and row increments.
  - After the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted → REPORT.
- REPORT: single cycle. Latch the working registers to the outputs, pulse bbox_valid, return to IDLE.
- Cycles with pixel_valid low: no state change; counters hold.

Run-length filter:
- run counter increments on a valid skin pixel and clears on a valid non-skin pixel or at line wrap. Runs never span lines.
- run saturates at MIN_RUN.
- Confirmation occurs on the pixel where run reaches MIN_RUN:
  - Candidate x_min = col-(MIN_RUN-1).
  - Candidate x_max = col.
  - Candidate y = row.
  - count += MIN_RUN.
- Each further skin pixel in the same run: x_max candidate = col, count += 1.
- Box update uses min/max against the working registers.
- The first confirmation of a frame loads the working registers directly; a has_skin flag tracks this.

Frame events and output rules:
- frame_start during ACCUM: working registers and counters cleared; the pixel is treated as (0,0) of a new frame. No report for the aborted frame.
- frame_start seen in REPORT is ignored. The upstream must not assert it within 1 cycle of the last pixel.
- No confirmation in a frame: x_min/x_max/y_min/y_max = 0, skin_count = 0, face_found = 0, bbox_valid still pulses.
- skin_count saturates at 2^19-1.
- Outputs hold between reports.
- Latency: bbox_valid asserts exactly 1 cycle after the last pixel's accepting edge.
- busy = 1 in ACCUM only.

Test Plan:
- Small frame (IMG_WIDTH=16, IMG_HEIGHT=8, MIN_RUN=4). Rows 2..5 skin at cols 5..12, else 0 → x_min=5, x_max=12, y_min=2, y_max=5, skin_count=32, bbox_valid one cycle after the last pixel.
- Same geometry; isolated runs of length 3 everywhere → skin_count=0, face_found=0, box=0, bbox_valid still pulses.
- Row with skin at cols 12..15 followed by the next row starting with skin at cols 0..2 → first run confirmed (x_max=15); second not confirmed (no cross-line run).
- Random pixel_valid gaps (≈50% duty) on scenario 1's image → identical outputs; bbox_valid one cycle after the final valid pixel.
- frame_start reasserted at row 3 of a frame with skin confined to rows 0..2, then a full clean frame with skin rows 6..7 → single report with y_min=6, y_max=7.
- rst_n pulsed low mid-frame → outputs immediately 0, busy=0, no bbox_valid. A following full frame reports correctly. face_found toggles at skin_count = MIN_PIXELS-1 vs MIN_PIXELS.
